// File: rtl/pcie_consumer_counter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_consumer_counter
// Purpose  : Drains the D0/D1 output FIFOs and keeps four per-destination,
//            per-VC word counters, cnt[{dest,vc}], where vc is the MSB of
//            each popped word. Counters can be read back one at a time
//            while the block is idle.
// Ports    : clk          - single clock, rising edge
//            reset        - asynchronous active-low reset
//            data_out0/1  - word from D0/D1 FIFO, valid the cycle after pop
//            D0/D1_can_pop- FIFO holds at least one word
//            pop_D0/D1    - read strobes to the FIFOs
//            req, idx     - counter read request and select {dest, vc}
//            count        - selected counter value (0 when not valid)
//            valid_count  - one-cycle qualifier for count
//            idle         - FSM is in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module pcie_consumer_counter #(
   parameter int BITNUMBER = 6,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BITNUMBER-1:0] data_out0,
   input  logic [BITNUMBER-1:0] data_out1,
   input  logic                 D0_can_pop,
   input  logic                 D1_can_pop,
   output logic                 pop_D0,
   output logic                 pop_D1,
   input  logic                 req,
   input  logic [1:0]           idx,
   output logic [CNT_W-1:0]     count,
   output logic                 valid_count,
   output logic                 idle
);

   localparam int               c_DATA_MSB = BITNUMBER - 1;
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_pop0;
   logic                      w_pop1;
   logic                      r_pend0;
   logic                      r_pend1;
   logic [1:0]                w_sel0;
   logic [1:0]                w_sel1;
   logic [3:0][CNT_W-1:0]     w_cnt;
   logic                      r_valid;
   logic [1:0]                r_rd_idx;
   logic                      w_unused_bits;

   // Only the VC bit of each word matters to this block.
   assign w_unused_bits = ^{data_out0[c_DATA_MSB-1:0], data_out1[c_DATA_MSB-1:0]};

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_RESET;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop0      = 1'b0;
      w_pop1      = 1'b0;
      case (r_state)
         ST_RESET: begin
            w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (D0_can_pop || D1_can_pop) begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            w_pop0 = D0_can_pop;
            w_pop1 = D1_can_pop;
            // Stay until the last popped word has been seen on data_outN.
            if (!D0_can_pop && !D1_can_pop && !r_pend0 && !r_pend1) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_RESET;
         end
      endcase
   end

   assign pop_D0 = w_pop0;
   assign pop_D1 = w_pop1;
   assign idle   = (r_state == ST_IDLE);

   // ------------------------------------------------------------------------
   // Pending flags: a pop this cycle means a word on data_outN next cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend0 <= 1'b0;
         r_pend1 <= 1'b0;
      end else begin
         r_pend0 <= w_pop0;
         r_pend1 <= w_pop1;
      end
   end

   // ------------------------------------------------------------------------
   // Word counters. D0 words only reach counters 0/1 and D1 words only
   // counters 2/3, so two simultaneous pends never collide.
   // ------------------------------------------------------------------------
   assign w_sel0 = {1'b0, data_out0[c_DATA_MSB]};
   assign w_sel1 = {1'b1, data_out1[c_DATA_MSB]};

   for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      localparam logic [1:0] c_ID = 2'(gi);
      logic             w_hit;
      logic [CNT_W-1:0] r_cnt;

      assign w_hit = (r_pend0 && (w_sel0 == c_ID)) || (r_pend1 && (w_sel1 == c_ID));

      // Free-running modulo-2^CNT_W count; wrap is intentional.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_cnt <= '0;
         end else if (w_hit) begin
            r_cnt <= r_cnt + c_CNT_ONE;
         end
      end

      assign w_cnt[gi] = r_cnt;
   end

   // ------------------------------------------------------------------------
   // Read-back. The select is latched on a req seen in IDLE and the counter
   // is shown the following cycle. A counter cannot move during that cycle
   // (the first pend only appears a cycle later), so a read that coincides
   // with IDLE->ACTIVE still returns the pre-increment value.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid  <= 1'b0;
         r_rd_idx <= 2'd0;
      end else begin
         r_valid <= (r_state == ST_IDLE) && req;
         if ((r_state == ST_IDLE) && req) begin
            r_rd_idx <= idx;
         end
      end
   end

   assign valid_count = r_valid;
   assign count       = r_valid ? w_cnt[r_rd_idx] : '0;

endmodule
`default_nettype wire

// File: doc/pcie_consumer_counter.md
PCIE_CONSUMER_COUNTER -- requirements
Module: pcie_consumer_counter

Interface
REQ-001 Parameter BITNUMBER, default 6, word width of the D0/D1 output FIFOs.
REQ-002 Parameter CNT_W, default 5, width of each word counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 data_out0  input  BITNUMBER  word from the D0 FIFO.
REQ-006 data_out1  input  BITNUMBER  word from the D1 FIFO.
REQ-007 D0_can_pop  input  1  D0 FIFO holds at least one word.
REQ-008 D1_can_pop  input  1  D1 FIFO holds at least one word.
REQ-009 pop_D0  output  1  read strobe to the D0 FIFO.
REQ-010 pop_D1  output  1  read strobe to the D1 FIFO.
REQ-011 req  input  1  counter read request.
REQ-012 idx  input  2  counter select: {dest, vc}, dest 0 = D0, 1 = D1.
REQ-013 count  output  CNT_W  selected counter value.
REQ-014 valid_count  output  1  count is valid this cycle.
REQ-015 idle  output  1  FSM is in IDLE.

Function
REQ-016 The block SHALL hold four counters, cnt[{dest,vc}], where vc = bit BITNUMBER-1 of the popped word.
REQ-017 The FSM SHALL have three states: RESET, IDLE and ACTIVE.
REQ-018 RESET SHALL be entered only by reset and SHALL go to IDLE on the first clk edge after reset deasserts.
REQ-019 IDLE SHALL go to ACTIVE on the edge where D0_can_pop or D1_can_pop is 1.
REQ-020 ACTIVE SHALL return to IDLE when both can_pop inputs are 0 and no read is pending.
REQ-021 A read is pending when a pop was issued in the previous cycle.
REQ-022 In ACTIVE, pop_Dn SHALL be combinationally equal to Dn_can_pop.
REQ-023 pop_Dn SHALL be 0 in every other state.
REQ-024 pop_D0 and pop_D1 MAY be asserted in the same cycle.
REQ-025 A word popped in cycle N SHALL appear on data_outn in cycle N+1.
REQ-026 The block SHALL register each pop into a pending flag, pend_n.
REQ-027 When pend_n is 1, cnt[{n, data_outn[BITNUMBER-1]}] SHALL increment at the end of cycle N+1.
REQ-028 Simultaneous pends from D0 and D1 SHALL both increment, since they target different counters.
REQ-029 Counters SHALL wrap modulo 2^CNT_W (31 -> 0 at the default width), with no saturation and no flag.
REQ-030 A req sampled high in IDLE SHALL latch idx.
REQ-031 After such a req, the next cycle SHALL drive count = cnt[idx] and valid_count = 1 for exactly one cycle.
REQ-032 A req held high in IDLE SHALL produce a fresh value and a valid pulse every cycle.
REQ-033 A req sampled in RESET or ACTIVE SHALL be ignored.
REQ-034 When valid_count = 0, count SHALL be 0.
REQ-035 Reading a counter SHALL NOT clear it.
REQ-036 If a req is sampled on the edge where IDLE goes to ACTIVE, the read SHALL still complete with the pre-increment value.
REQ-037 idle SHALL be 1 exactly when the state is IDLE.

Reset
REQ-038 While reset = 0, the block SHALL force state RESET, all counters and pend flags to 0, pop_D0 = pop_D1 = 0, count = 0, valid_count = 0 and idle = 0, asynchronously.
REQ-039 Reset asserted mid-operation SHALL discard any pending word without counting it.
REQ-040 Reset SHALL take precedence over every other input.

Verification
REQ-041 Release reset with both can_pop = 0 -> idle = 1 after one edge, pops = 0, all counters 0.
REQ-042 D0 FIFO supplies 3 words 0x21, 0x01, 0x25 -> pop_D0 high for 3 cycles; after return to IDLE, req with idx = 0 gives count 1, and idx = 1 gives count 2.
REQ-043 Both FIFOs supply 4 words with bit 5 = 0 in the same cycles -> cnt[0] = 4 and cnt[2] = 4, with pop_D0 and pop_D1 concurrent.
REQ-044 Push 33 words with bit 5 = 1 through D1 -> cnt[3] reads 1 (wrap), and the other counters read 0.
REQ-045 Assert reset while pend_0 = 1 -> all outputs 0 immediately, and the word is not counted after release.
REQ-046 Hold req = 1 in ACTIVE -> valid_count stays 0; on return to IDLE, valid_count pulses the cycle after the first IDLE sample.
